// File: rtl/mux8_tdm_pkg.sv
// Shared types and constants for the 8-lane TDM transmitter.
package mux8_tdm_pkg;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {IDLE = 1'b0, SLOT = 1'b1} state_e;
endpackage

// File: rtl/mux8_tdm_next_ch.sv
// Combinational search for the next enabled lane index in a channel mask.
module mux8_next_ch
  import mux8_tdm_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  input  logic              first,
  output logic [SEL_W-1:0]  nxt,
  output logic              found
);

  // Scan downward so the lowest qualifying index is the one left standing.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cur)))) begin
        nxt   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_tdm_tx.sv
// Eight-lane time-division transmitter: serializes enabled lanes onto one line
// with a slot tag, holding each slot for DWELL cycles.
//   state | meaning
//   IDLE  | no frame in progress, outputs parked at 0, waiting for start
//   SLOT  | a lane is on the line; dwell counter runs toward DWELL-1
module mux8_tdm_tx
  import mux8_tdm_pkg::*;
#(
  parameter int DWELL = 1,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              in1,
  input  logic              in2,
  input  logic              in3,
  input  logic              in4,
  input  logic              in5,
  input  logic              in6,
  input  logic              in7,
  input  logic              in8,
  output logic              out,
  output logic [SEL_W-1:0]  sel,
  output logic              valid,
  output logic              frame_start,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               out_q, out_d;
  logic               valid_q, valid_d;
  logic               fs_q, fs_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_CH-1:0]  lanes;
  logic [SEL_W-1:0]   first_nxt, next_nxt;
  logic               first_found, next_found;
  logic               dwell_done;

  assign lanes      = {in8, in7, in6, in5, in4, in3, in2, in1};
  assign dwell_done = (cnt_q == CNT_W'(DWELL - 1));

  // First-slot search always looks at the live mask; next-slot uses the latched one.
  mux8_next_ch u_first (
    .mask  (ch_mask),
    .cur   ('0),
    .first (1'b1),
    .nxt   (first_nxt),
    .found (first_found)
  );

  mux8_next_ch u_next (
    .mask  (mask_q),
    .cur   (sel_q),
    .first (1'b0),
    .nxt   (next_nxt),
    .found (next_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && first_found) state_d = SLOT;
      SLOT: if (dwell_done && !next_found && !(cont && first_found)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d   = sel_q;
    out_d   = out_q;
    valid_d = valid_q;
    fs_d    = 1'b0;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start && first_found) begin
          mask_d  = ch_mask;
          sel_d   = first_nxt;
          out_d   = lanes[first_nxt];
          valid_d = 1'b1;
          fs_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      SLOT: begin
        if (!dwell_done) begin
          cnt_d = cnt_q + 1'b1;
        end else if (next_found) begin
          sel_d = next_nxt;
          out_d = lanes[next_nxt];
          cnt_d = '0;
        end else if (cont && first_found) begin
          mask_d = ch_mask;
          sel_d  = first_nxt;
          out_d  = lanes[first_nxt];
          fs_d   = 1'b1;
          cnt_d  = '0;
        end else begin
          sel_d   = '0;
          out_d   = 1'b0;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        sel_d   = '0;
        out_d   = 1'b0;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign out         = out_q;
  assign sel         = sel_q;
  assign valid       = valid_q;
  assign frame_start = fs_q;
  assign busy        = (state_q == SLOT);

endmodule
